// File: rtl/hs_bus_arbiter_if.sv
// Bundles the requester-side and server-side four-phase handshakes of the arbiter.
// The master modport is the arbiter's view; slave is the view of the attached environment.
interface hs_bus_arbiter_if #(
  parameter int N_CLIENTS = 4,
  parameter int DATA_W    = 4
);
  logic [N_CLIENTS-1:0] cli_ready;
  logic [N_CLIENTS-1:0] cli_srv_ready;
  logic [DATA_W-1:0]    cli_data;
  logic                 srv_client_ready;
  logic                 srv_server_ready;
  logic [DATA_W-1:0]    srv_data;

  modport master (
    input  cli_ready,
    output cli_srv_ready,
    output cli_data,
    output srv_client_ready,
    input  srv_server_ready,
    input  srv_data
  );

  modport slave (
    output cli_ready,
    input  cli_srv_ready,
    input  cli_data,
    input  srv_client_ready,
    output srv_server_ready,
    output srv_data
  );
endinterface

// File: rtl/hs_bus_arbiter.sv
// Round-robin arbiter sharing one four-phase data server among N_CLIENTS requesters.
// Every output is a register; the server handshake always runs to completion.
module hs_bus_arbiter #(
  parameter int N_CLIENTS = 4,
  parameter int DATA_W    = 4,
  localparam int IDW      = $clog2(N_CLIENTS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hs_bus_arbiter_if.master     bus,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy,
  output logic [15:0]          xfer_count
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [IDW-1:0]       grant_q, grant_d;
  logic                 abort_q, abort_d;
  logic                 srv_req_q, srv_req_d;
  logic [N_CLIENTS-1:0] ack_q, ack_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic                 busy_q, busy_d;
  logic [15:0]          cnt_q, cnt_d;

  logic                 found;
  logic [IDW-1:0]       win;
  int                   j;

  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
    return (int'(i) == N_CLIENTS - 1) ? '0 : i + 1'b1;
  endfunction

  // Search ptr, ptr+1, ... (mod N_CLIENTS) for the first pending request
  always_comb begin
    found = 1'b0;
    win   = '0;
    j     = 0;
    for (int k = 0; k < N_CLIENTS; k++) begin
      j = int'(ptr_q) + k;
      if (j >= N_CLIENTS) j = j - N_CLIENTS;
      if (!found && bus.cli_ready[j]) begin
        found = 1'b1;
        win   = IDW'(j);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    abort_d   = abort_q;
    srv_req_d = srv_req_q;
    ack_d     = ack_q;
    data_d    = data_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d   = win;
          abort_d   = 1'b0;
          srv_req_d = 1'b1;
          busy_d    = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (bus.srv_server_ready) begin
          srv_req_d = 1'b0;
          if (abort_q || !bus.cli_ready[grant_q]) begin
            state_d = DRAIN;
          end else begin
            data_d         = bus.srv_data;
            ack_d          = '0;
            ack_d[grant_q] = 1'b1;
            state_d        = RESP;
          end
        end else if (!bus.cli_ready[grant_q]) begin
          // Requester gave up; finish the server handshake but deliver nothing
          abort_d = 1'b1;
        end
      end
      RESP: begin
        if (!bus.cli_ready[grant_q] && !bus.srv_server_ready) begin
          ack_d   = '0;
          cnt_d   = cnt_q + 16'd1;
          ptr_d   = next_idx(grant_q);
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (!bus.srv_server_ready) begin
          ptr_d   = next_idx(grant_q);
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      abort_q   <= 1'b0;
      srv_req_q <= 1'b0;
      ack_q     <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      abort_q   <= abort_d;
      srv_req_q <= srv_req_d;
      ack_q     <= ack_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.cli_srv_ready    = ack_q;
  assign bus.cli_data         = data_q;
  assign bus.srv_client_ready = srv_req_q;
  assign grant_id             = grant_q;
  assign busy                 = busy_q;
  assign xfer_count           = cnt_q;

endmodule

// File: tb/tb_hs_bus_arbiter.sv
// Directed bench for hs_bus_arbiter: inputs change and outputs are checked on the falling edge.
module tb_hs_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  grant_id;
  logic        busy;
  logic [15:0] xfer_count;
  int          n_pass = 0;
  int          n_total = 0;
  int          exp_cnt = 0;

  hs_bus_arbiter_if #(.N_CLIENTS(4), .DATA_W(4)) bi ();

  hs_bus_arbiter #(.N_CLIENTS(4), .DATA_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bi),
    .grant_id   (grant_id),
    .busy       (busy),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ack"},   32'(bi.cli_srv_ready), 0);
    chk({tag, "_data"},  32'(bi.cli_data), 0);
    chk({tag, "_sreq"},  32'(bi.srv_client_ready), 0);
    chk({tag, "_grant"}, 32'(grant_id), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_count"}, 32'(xfer_count), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bi.cli_ready = '0;
    bi.srv_server_ready = 1'b0;
    bi.srv_data = '0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_cnt = 0;
  endtask

  // One full transfer for client g; the pending cli_ready pattern is set by the caller
  task automatic xfer(input int g, input logic [3:0] d, input bit rereq);
    tick();
    chk("srv_req", 32'(bi.srv_client_ready), 1);
    chk("grant", 32'(grant_id), g);
    chk("busy_req", 32'(busy), 1);
    chk("ack_in_req", 32'(bi.cli_srv_ready), 0);
    bi.srv_server_ready = 1'b1;
    bi.srv_data = d;
    tick();
    chk("ack", 32'(bi.cli_srv_ready), 32'(1) << g);
    chk("ack_onehot", 32'($countones(bi.cli_srv_ready) <= 1), 1);
    chk("data", 32'(bi.cli_data), 32'(d));
    chk("srv_drop", 32'(bi.srv_client_ready), 0);
    bi.cli_ready[g] = 1'b0;
    bi.srv_server_ready = 1'b0;
    tick();
    exp_cnt++;
    chk("ack_rel", 32'(bi.cli_srv_ready), 0);
    chk("count", 32'(xfer_count), exp_cnt);
    chk("busy_rel", 32'(busy), 0);
    if (rereq) bi.cli_ready[g] = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    bi.cli_ready = '0;
    bi.srv_server_ready = 1'b0;
    bi.srv_data = '0;
    tick();
    chk_reset_outputs("rst");
    rst_n = 1'b1;

    // Single requester
    bi.cli_ready = 4'b0001;
    chk("sreq_before", 32'(bi.srv_client_ready), 0);
    xfer(0, 4'hA, 1'b0);

    // Full contention from ptr=0 with immediate re-requests
    do_reset();
    bi.cli_ready = 4'b1111;
    xfer(0, 4'h1, 1'b1);
    xfer(1, 4'h2, 1'b1);
    xfer(2, 4'h3, 1'b1);
    xfer(3, 4'h4, 1'b1);
    xfer(0, 4'h5, 1'b0);
    bi.cli_ready = '0;
    tick();
    tick();
    chk("idle_after_contention", 32'(busy), 0);

    // Pointer rotation: ptr=1, serve 2, then 1 and 3 together -> 3 then 1
    bi.cli_ready = 4'b0100;
    xfer(2, 4'h6, 1'b0);
    bi.cli_ready = 4'b1010;
    xfer(3, 4'h8, 1'b0);
    xfer(1, 4'h9, 1'b0);

    // Abandon: ptr=2, client 1 requests then drops in REQ
    bi.cli_ready = 4'b0010;
    tick();
    chk("ab_grant", 32'(grant_id), 1);
    chk("ab_sreq", 32'(bi.srv_client_ready), 1);
    bi.cli_ready = 4'b0000;
    tick();
    chk("ab_hold_sreq", 32'(bi.srv_client_ready), 1);
    bi.srv_server_ready = 1'b1;
    bi.srv_data = 4'h7;
    tick();
    chk("ab_no_ack", 32'(bi.cli_srv_ready), 0);
    chk("ab_sreq_drop", 32'(bi.srv_client_ready), 0);
    chk("ab_busy_drain", 32'(busy), 1);
    chk("ab_data_kept", 32'(bi.cli_data), 32'h9);
    bi.srv_server_ready = 1'b0;
    tick();
    chk("ab_busy_rel", 32'(busy), 0);
    chk("ab_count", 32'(xfer_count), exp_cnt);
    chk("ab_no_ack2", 32'(bi.cli_srv_ready), 0);
    bi.cli_ready = 4'b1001;
    xfer(3, 4'hB, 1'b0);
    xfer(0, 4'hC, 1'b0);

    // Release ordering: client drops first, server holds 3 more cycles
    bi.cli_ready = 4'b0100;
    tick();
    chk("ro_grant", 32'(grant_id), 2);
    bi.srv_server_ready = 1'b1;
    bi.srv_data = 4'hD;
    tick();
    chk("ro_ack", 32'(bi.cli_srv_ready), 32'h4);
    bi.cli_ready = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ro_hold_ack", 32'(bi.cli_srv_ready), 32'h4);
      chk("ro_hold_count", 32'(xfer_count), exp_cnt);
    end
    bi.srv_server_ready = 1'b0;
    tick();
    exp_cnt++;
    chk("ro_rel_ack", 32'(bi.cli_srv_ready), 0);
    chk("ro_rel_count", 32'(xfer_count), exp_cnt);
    // Both release conditions on the same edge
    bi.cli_ready = 4'b1000;
    xfer(3, 4'hE, 1'b0);

    // Asynchronous reset while in RESP
    bi.cli_ready = 4'b0001;
    tick();
    bi.srv_server_ready = 1'b1;
    bi.srv_data = 4'h5;
    tick();
    chk("rr_in_resp", 32'(bi.cli_srv_ready), 32'h1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    bi.cli_ready = '0;
    bi.srv_server_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_cnt = 0;
    bi.cli_ready = 4'b1000;
    xfer(3, 4'h3, 1'b0);
    // ptr is 0 after the post-reset transfer from client 3: 0 beats 2
    bi.cli_ready = 4'b0101;
    xfer(0, 4'h1, 1'b0);
    xfer(2, 4'h2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
